// File: rtl/cpu_axi_bridge_pkg.sv
// Shared state encoding, AXI IDs/sizes and the latched request payload for cpu_axi_bridge.
package cpu_axi_bridge_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = 4;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned SIZE_BITS = 3;

    localparam int unsigned INST_ID = 0;
    localparam int unsigned DATA_ID = 1;

    localparam logic [SIZE_BITS-1:0] SIZE_B = 3'd0;
    localparam logic [SIZE_BITS-1:0] SIZE_H = 3'd1;
    localparam logic [SIZE_BITS-1:0] SIZE_W = 3'd2;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_AWW, D_B} state_e;

    typedef struct packed {
        logic                 is_data;
        logic [ADDR_W-1:0]    addr;
        logic [STRB_W-1:0]    sel;
        logic [DATA_W-1:0]    wdata;
        logic [SIZE_BITS-1:0] size;
    } req_t;

    // Narrowest AXI size covering a contiguous byte-enable pattern.
    function automatic logic [SIZE_BITS-1:0] size_from_sel(input logic [STRB_W-1:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_from_sel = SIZE_B;
            4'b0011, 4'b1100:                   size_from_sel = SIZE_H;
            default:                            size_from_sel = SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/bridge_port_buf.sv
// Done flag and returned-word buffer for one core port; a killed request's beat is dropped.
module bridge_port_buf
    import cpu_axi_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              kill,
    input  logic              release_en,
    input  logic [DATA_W-1:0] din,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    logic killed;

    // Kill is sticky until the in-flight beat returns; capture outranks the release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            dout   <= '0;
            killed <= 1'b0;
        end else if (capture) begin
            killed <= 1'b0;
            if (!(kill || killed)) begin
                done <= 1'b1;
                dout <= din;
            end else if (release_en) begin
                done <= 1'b0;
            end
        end else begin
            if (kill) begin
                killed <= 1'b1;
            end
            if (release_en) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Single-outstanding AXI master serving the MIPS core's fetch and load/store ports.
// Define CPU_AXI_BRIDGE_NARROW_SIZE_EN to size data beats from the byte enables.
module cpu_axi_bridge
    import cpu_axi_bridge_pkg::*;
#(
    parameter int unsigned ID_W = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 inst_en,
    input  logic [ADDR_W-1:0]    inst_addr,
    output logic [DATA_W-1:0]    inst_rdata,
    output logic                 i_stall,
    input  logic                 data_en,
    input  logic                 data_wr,
    input  logic [STRB_W-1:0]    data_sel,
    input  logic [ADDR_W-1:0]    data_addr,
    input  logic [DATA_W-1:0]    data_wdata,
    output logic [DATA_W-1:0]    data_rdata,
    output logic                 d_stall,
    input  logic                 longest_stall,
    output logic [ID_W-1:0]      arid,
    output logic [ADDR_W-1:0]    araddr,
    output logic [LEN_W-1:0]     arlen,
    output logic [SIZE_BITS-1:0] arsize,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [ID_W-1:0]      rid,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready,
    output logic [ID_W-1:0]      awid,
    output logic [ADDR_W-1:0]    awaddr,
    output logic [LEN_W-1:0]     awlen,
    output logic [SIZE_BITS-1:0] awsize,
    output logic                 awvalid,
    input  logic                 awready,
    output logic [DATA_W-1:0]    wdata,
    output logic [STRB_W-1:0]    wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    input  logic                 bvalid,
    output logic                 bready
);

    state_e            state;
    req_t              req;
    req_t              i_req;
    req_t              d_req;
    logic              i_done;
    logic              d_done;
    logic              i_cap;
    logic              i_kill;
    logic              d_cap;
    logic [DATA_W-1:0] d_din;
    logic              unused_rid;

    assign i_stall    = inst_en & ~i_done;
    assign d_stall    = data_en & ~d_done;
    assign unused_rid = ^rid;

    // Candidate requests as they will be latched on leaving IDLE.
    always_comb begin
        i_req         = '0;
        i_req.addr    = inst_addr & WORD_MASK;
        i_req.sel     = '1;
        i_req.size    = SIZE_W;
        d_req         = '0;
        d_req.is_data = 1'b1;
        d_req.sel     = data_sel;
        d_req.wdata   = data_wdata;
`ifdef CPU_AXI_BRIDGE_NARROW_SIZE_EN
        d_req.addr    = data_addr;
        d_req.size    = size_from_sel(data_sel);
`else
        d_req.addr    = data_addr & WORD_MASK;
        d_req.size    = SIZE_W;
`endif
    end

    assign arid   = req.is_data ? ID_W'(DATA_ID) : ID_W'(INST_ID);
    assign araddr = req.addr;
    assign arlen  = '0;
    assign arsize = req.size;
    assign awid   = ID_W'(DATA_ID);
    assign awaddr = req.addr;
    assign awlen  = '0;
    assign awsize = req.size;
    assign wdata  = req.wdata;
    assign wstrb  = req.sel;
    assign wlast  = 1'b1;

    assign i_cap  = (state == I_R) & rvalid & rlast;
    assign i_kill = ((state == I_AR) | (state == I_R)) & ~inst_en;
    assign d_cap  = ((state == D_R) & rvalid & rlast) | ((state == D_B) & bvalid);
    // A store completion re-captures the current word so data_rdata is left untouched.
    assign d_din  = (state == D_R) ? rdata : data_rdata;

    bridge_port_buf u_inst_buf (
        .clk        (aclk),
        .rst_n      (aresetn),
        .capture    (i_cap),
        .kill       (i_kill),
        .release_en (~longest_stall),
        .din        (rdata),
        .done       (i_done),
        .dout       (inst_rdata)
    );

    bridge_port_buf u_data_buf (
        .clk        (aclk),
        .rst_n      (aresetn),
        .capture    (d_cap),
        .kill       (1'b0),
        .release_en (~longest_stall),
        .din        (d_din),
        .done       (d_done),
        .dout       (data_rdata)
    );

    // Transaction sequencer; data requests win over fetches in IDLE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            req     <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_stall) begin
                        req <= d_req;
                        if (data_wr) begin
                            state   <= D_AWW;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= D_AR;
                            arvalid <= 1'b1;
                        end
                    end else if (i_stall) begin
                        req     <= i_req;
                        state   <= I_AR;
                        arvalid <= 1'b1;
                    end
                end
                I_AR, D_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= (state == I_AR) ? I_R : D_R;
                    end
                end
                I_R, D_R: begin
                    if (rvalid && rlast) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                D_AWW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        state  <= D_B;
                        bready <= 1'b1;
                    end
                end
                D_B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

- Sits directly downstream of the pipelined MIPS core.
- Converts the core's two SRAM-like ports (instruction fetch, data load/store) into a single AXI master with one outstanding transaction.
- Generates the `i_stall`/`d_stall` signals the core's hazard unit consumes.
- Holds returned data stable until the core's global stall releases.

## Interface

Parameters:
- `ID_W`, 4 — AXI ID width. Instruction transactions use ID 0; data transactions use ID 1.

Ports:
- `aclk`  in  1  — single clock. Reset is asynchronous and active-low.
- `aresetn`  in  1  — asynchronous active-low reset.
- `inst_en`  in  1  — fetch request. Deassertion mid-transaction means the fetch is killed (exception).
- `inst_addr`  in  32  — fetch PC.
- `inst_rdata`  out  32  — fetched instruction.
- `i_stall`  out  1  — fetch not yet satisfied.
- `data_en`  in  1  — load or store request.
- `data_wr`  in  1  — 1 = store.
- `data_sel`  in  4  — byte enables.
- `data_addr`  in  32  — byte address.
- `data_wdata`  in  32  — store data, already lane-aligned.
- `data_rdata`  out  32  — load data, raw word.
- `d_stall`  out  1  — data access not yet satisfied.
- `longest_stall`  in  1  — core global stall. Low means the core advances this cycle.
- AR channel: `arid`/`araddr`/`arlen`/`arsize`/`arvalid` out, `arready` in.
- R channel: `rid`/`rdata`/`rlast`/`rvalid` in, `rready` out.
- AW channel: `awid`/`awaddr`/`awlen`/`awsize`/`awvalid` out, `awready` in.
- W channel: `wdata`/`wstrb`/`wlast`/`wvalid` out, `wready` in.
- B channel: `bvalid` in, `bready` out.
- `arlen`/`awlen` are fixed 0. `wlast` is fixed 1.

## Operation

FSM states: IDLE, I_AR, I_R, D_AR, D_R, D_AWW, D_B.

IDLE:
- If `data_en & ~d_done`: go to D_AWW when `data_wr`, else D_AR. Data has priority.
- Else if `inst_en & ~i_done`: go to I_AR.
- Address, sel and wdata are latched on leaving IDLE.

I_AR / D_AR:
- `arvalid`=1 with the latched address.
- On `arready`, go to I_R / D_R.

I_R / D_R:
- `rready`=1.
- On `rvalid & rlast`:
  - capture `rdata` into the port buffer;
  - set `i_done`/`d_done`;
  - return to IDLE.

D_AWW:
- `awvalid` and `wvalid` both raised. Each drops independently on its own handshake.
- Go to D_B once both handshakes have occurred (same or different cycles).

D_B:
- `bready`=1.
- On `bvalid`: set `d_done`, return to IDLE.

Stall and done flags:
- `i_stall = inst_en & ~i_done`
- `d_stall = data_en & ~d_done`
- Both are combinational.
- Done flags clear on any edge where `longest_stall`=0.

Kill:
- If `inst_en` drops while I_AR/I_R is in flight, the AXI transaction still completes.
- The returned data is discarded and `i_done` is not set.

Arithmetic:
- `awaddr`/`araddr` = latched address with [1:0] forced to 0 when size=2.
- `wstrb` = latched `data_sel`.

## Timing

Reset values:
- All `*valid`/`*ready` outputs = 0.
- `inst_rdata` = `data_rdata` = 0.
- Done flags = 0.
- FSM = IDLE.
- `i_stall`/`d_stall` follow their equations.

Latency:
- Request first high in cycle 0.
- `arvalid` high in cycle 1.
- With `arready`=1 and `rvalid` in cycle 2, `inst_rdata` is valid and `i_stall`=0 in cycle 3.
- Writes: AW/W in cycle 1, B in cycle 2, `d_stall`=0 in cycle 3.

Hold:
- A buffered word stays on `*_rdata` and its done flag stays set for as long as `longest_stall`=1, e.g. while the other port is still pending.
- No re-issue occurs during the hold.

Simultaneous events:
- Both ports requesting in IDLE: data is served first, then inst, with no IDLE bubble beyond one cycle.
- Done-clear and a new request in the same cycle: the clear wins. The new request is seen the next cycle.

Asynchronous reset mid-transaction:
- Immediate return to reset values.
- No attempt to finish the AXI handshake.

## Configuration

`CPU_AXI_BRIDGE_NARROW_SIZE_EN`:
- Defined: `arsize`/`awsize` derived from `data_sel`:
  - one bit set → 0;
  - 4'b0011 or 4'b1100 → 1;
  - otherwise → 2.
- Address low bits are passed unmodified.
- Undefined: size fixed at 2 for every transaction, address [1:0] forced to 0.
- Instruction fetch always uses size 2.

## Structure

- Package `cpu_axi_bridge_pkg`:
  - FSM state enum;
  - `INST_ID`=0, `DATA_ID`=1;
  - `SIZE_B`/`SIZE_H`/`SIZE_W` encodings.
- Sub-module `bridge_port_buf`, instantiated twice (inst, data):
  - holds the done flag and the 32-bit data register;
  - inputs: capture, kill, release (`~longest_stall`).

## Test plan

1. Fetch 0xBFC00000, `arready`=1, `rvalid` with 0x3C08BFAF one cycle later → `araddr`=0xBFC00000, `arid`=0, `inst_rdata`=0x3C08BFAF, `i_stall` low in cycle 3.
2. Simultaneous fetch and load of 0x80001000 → AR for ID 1 (data) precedes AR for ID 0. Both stalls drop only after their own R beat. Data is held until `longest_stall` falls.
3. Store `data_sel`=4'b0010, `wdata`=0x0000AB00, `awready` two cycles after `wready` → `wstrb`=0010. D_B is entered only after both handshakes. `d_stall` falls after `bvalid`.
4. `inst_en` dropped while in I_R → R beat accepted, `inst_rdata` unchanged, `i_stall`=0, next fetch issues normally.
5. `aresetn` pulsed low during D_AWW → `awvalid`/`wvalid` are 0 immediately and the FSM is in IDLE.
6. With `CPU_AXI_BRIDGE_NARROW_SIZE_EN`, `sel`=4'b1100 at 0x80000002 → `awsize`=1, `awaddr`=0x80000002. Without the macro → `awsize`=2, `awaddr`=0x80000000.
